// File: rtl/grid_scanner.sv
// Frame scanner: walks every (x, y) cell of the grid in row-major order, encodes the
// classifier outputs into a colour code and offers each cell to a valid/ready sink.
module grid_scanner #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] x,
    output logic [3:0] y,
    input  logic       isBorder,
    input  logic       isHead,
    input  logic       isBody,
    input  logic       isApple,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic [2:0] pix_color,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_cnt,
    output logic [1:0] dbg_state
);

    // Handshake: a cell transfers on a rising edge where pix_valid & pix_ready are both
    // high; once pix_valid rises, pix_color/x/y stay frozen until that transfer.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] X_LAST = 4'(GRID_W - 1);
    localparam logic [3:0] Y_LAST = 4'(GRID_H - 1);

    state_t     state_q;
    logic [3:0] x_q;
    logic [3:0] y_q;
    logic [2:0] color_q;
    logic [2:0] color_d;
    logic       valid_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] cnt_q;

    // Border outranks the snake, which outranks the apple.
    always_comb begin
        color_d = 3'd0;
        if (isBorder) begin
            color_d = 3'd1;
        end else if (isHead) begin
            color_d = 3'd2;
        end else if (isBody) begin
            color_d = 3'd3;
        end else if (isApple) begin
            color_d = 3'd4;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= 4'd0;
            y_q     <= 4'd0;
            color_q <= 3'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    color_q <= color_d;
                    valid_q <= 1'b1;
                    state_q <= SEND;
                end
                SEND: begin
                    if (pix_ready) begin
                        valid_q <= 1'b0;
                        if (x_q != X_LAST) begin
                            x_q     <= x_q + 4'd1;
                            state_q <= FETCH;
                        end else if (y_q != Y_LAST) begin
                            x_q     <= 4'd0;
                            y_q     <= y_q + 4'd1;
                            state_q <= FETCH;
                        end else begin
                            x_q     <= 4'd0;
                            y_q     <= 4'd0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    cnt_q   <= cnt_q + 8'd1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign pix_valid  = valid_q;
    assign pix_color  = color_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_cnt  = cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_grid_scanner.sv
// Directed bench for grid_scanner: full 16x12 frames against a row-major expected
// queue, back-pressure, ignored start, mid-frame reset, and frame counter wrap.
module tb_grid_scanner;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] x;
    logic [3:0] y;
    logic       isBorder;
    logic       isHead;
    logic       isBody;
    logic       isApple;
    logic       pix_valid;
    logic       pix_ready;
    logic [2:0] pix_color;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_cnt;
    logic [1:0] dbg_state;

    // Small 2x2 instance used to wrap the frame counter quickly.
    logic       start2;
    logic [3:0] x2;
    logic [3:0] y2;
    logic       zero2;
    logic       ready2;
    logic       pix_valid2;
    logic [2:0] pix_color2;
    logic       busy2;
    logic       frame_done2;
    logic [7:0] frame_cnt2;
    logic [1:0] dbg_state2;

    logic       border_en;
    logic       head_map  [16][16];
    logic       body_map  [16][16];
    logic       apple_map [16][16];

    logic [10:0] exp_q[$];
    logic [7:0]  exp_cnt;
    int          total;
    int          bad;
    int          done2_hi;

    grid_scanner #(.GRID_W(16), .GRID_H(12)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .isBorder(isBorder), .isHead(isHead), .isBody(isBody), .isApple(isApple),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_color(pix_color),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
    );

    grid_scanner #(.GRID_W(2), .GRID_H(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .x(x2), .y(y2),
        .isBorder(zero2), .isHead(zero2), .isBody(zero2), .isApple(zero2),
        .pix_valid(pix_valid2), .pix_ready(ready2), .pix_color(pix_color2),
        .busy(busy2), .frame_done(frame_done2), .frame_cnt(frame_cnt2), .dbg_state(dbg_state2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Border generator plus bench-owned snake/apple maps.
    assign isBorder = border_en && (x == 4'd0 || x == 4'd15 || y == 4'd0 || y == 4'd11);
    assign isHead   = head_map[x][y];
    assign isBody   = body_map[x][y];
    assign isApple  = apple_map[x][y];
    assign zero2    = 1'b0;
    assign ready2   = 1'b1;

    always @(posedge clk) begin
        if (frame_done2) done2_hi <= done2_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_color(input int cx, input int cy);
        logic [2:0] c;
        c = 3'd0;
        if (border_en && (cx == 0 || cx == 15 || cy == 0 || cy == 11)) c = 3'd1;
        else if (head_map[cx][cy])  c = 3'd2;
        else if (body_map[cx][cy])  c = 3'd3;
        else if (apple_map[cx][cy]) c = 3'd4;
        return c;
    endfunction

    task automatic clear_maps();
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                head_map[i][j]  = 1'b0;
                body_map[i][j]  = 1'b0;
                apple_map[i][j] = 1'b0;
            end
        end
    endtask

    // Drives one frame; optional stall, start poke in SEND, start in DONE, mid-frame abort.
    task automatic run_frame(input int stall_x, input int stall_y, input int stall_n,
                             input int poke_x, input int poke_y, input bit poke_done,
                             input int abort_x, input int abort_y, input int exp_done_cyc);
        int          cyc;
        int          stall_left;
        bit          fin;
        bit          aborted;
        bit          stalled;
        logic [10:0] item;
        exp_q.delete();
        for (int cy = 0; cy < 12; cy++) begin
            for (int cx = 0; cx < 16; cx++) begin
                exp_q.push_back({cx[3:0], cy[3:0], model_color(cx, cy)});
            end
        end
        stall_left = stall_n;
        fin        = 1'b0;
        aborted    = 1'b0;
        @(posedge clk); #1;
        start     = 1'b1;
        pix_ready = 1'b1;
        cyc       = 1;
        @(negedge clk);
        check("idle before start busy", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 2;
        check("fetch busy", busy, 1);
        check("fetch no valid", pix_valid, 0);
        @(posedge clk); #1;
        cyc = 3;
        check("first valid latency", pix_valid, 1);
        while (!fin && cyc < 1000) begin
            pix_ready = 1'b1;
            start     = 1'b0;
            stalled   = 1'b0;
            if (pix_valid && x == stall_x && y == stall_y && stall_left > 0) begin
                pix_ready = 1'b0;
                stalled   = 1'b1;
                stall_left--;
            end
            if (pix_valid && x == poke_x && y == poke_y) start = 1'b1;
            if (pix_valid && x == abort_x && y == abort_y) begin
                #2;
                rst = 1'b1;
                #1;
                check("abort x", x, 0);
                check("abort y", y, 0);
                check("abort valid", pix_valid, 0);
                check("abort color", pix_color, 0);
                check("abort busy", busy, 0);
                check("abort frame_done", frame_done, 0);
                check("abort frame_cnt", frame_cnt, 0);
                check("abort state", dbg_state, 0);
                exp_cnt = 8'd0;
                #1;
                rst     = 1'b0;
                fin     = 1'b1;
                aborted = 1'b1;
            end else begin
                @(negedge clk);
                if (stalled) begin
                    check("stall valid held", pix_valid, 1);
                    check("stall x held", x, stall_x);
                    check("stall y held", y, stall_y);
                    check("stall color held", pix_color, model_color(stall_x, stall_y));
                end
                if (frame_done) begin
                    check("frame_done cycle", cyc, exp_done_cyc);
                    check("all cells sent", exp_q.size(), 0);
                    check("done busy", busy, 1);
                    if (poke_done) start = 1'b1;
                    fin = 1'b1;
                end
                if (pix_valid && pix_ready) begin
                    check("cell within frame", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        item = exp_q.pop_front();
                        check("cell x", x, item[10:7]);
                        check("cell y", y, item[6:3]);
                        check("cell color", pix_color, item[2:0]);
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        if (!fin) begin
            check("frame timeout cycle", cyc, exp_done_cyc);
        end else if (!aborted) begin
            exp_cnt++;
            check("frame_cnt after frame", frame_cnt, exp_cnt);
            check("frame_done one cycle", frame_done, 0);
            check("idle busy", busy, 0);
            check("idle x", x, 0);
            check("idle y", y, 0);
            check("idle state", dbg_state, 0);
            if (poke_done) begin
                @(posedge clk); #1;
                check("start in DONE not latched", busy, 0);
                check("no second frame_done", frame_done, 0);
            end
        end
    endtask

    initial begin
        int w;
        total     = 0;
        bad       = 0;
        done2_hi  = 0;
        exp_cnt   = 8'd0;
        rst       = 1'b1;
        start     = 1'b0;
        start2    = 1'b0;
        pix_ready = 1'b0;
        border_en = 1'b0;
        clear_maps();

        // Reset values before any clock edge.
        #2;
        check("reset x", x, 0);
        check("reset y", y, 0);
        check("reset valid", pix_valid, 0);
        check("reset color", pix_color, 0);
        check("reset busy", busy, 0);
        check("reset frame_done", frame_done, 0);
        check("reset frame_cnt", frame_cnt, 0);
        #20;
        rst = 1'b0;

        // Border-only frame, ready held high.
        border_en = 1'b1;
        run_frame(-1, -1, 0, -1, -1, 1'b0, -1, -1, 386);

        // Priority cells, stall at (3,2), start pokes in SEND and in DONE.
        head_map[5][5]  = 1'b1;
        head_map[0][5]  = 1'b1;
        body_map[5][5]  = 1'b1;
        apple_map[5][5] = 1'b1;
        run_frame(3, 2, 7, 8, 4, 1'b1, -1, -1, 393);

        // Body+apple at (5,5), then reset mid-frame at (10,6).
        head_map[5][5] = 1'b0;
        head_map[0][5] = 1'b0;
        run_frame(-1, -1, 0, -1, -1, 1'b0, 10, 6, 386);

        // Fresh frame after the abort restarts at (0,0).
        clear_maps();
        run_frame(-1, -1, 0, -1, -1, 1'b0, -1, -1, 386);

        // 256 frames on the small instance: counter wraps to 0.
        @(posedge clk); #1;
        done2_hi = 0;
        for (int f = 0; f < 256; f++) begin
            start2 = 1'b1;
            @(posedge clk); #1;
            start2 = 1'b0;
            w = 0;
            while (!frame_done2 && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            check("small frame_done seen", frame_done2, 1);
            @(posedge clk); #1;
            check("small frame_done width", frame_done2, 0);
            check("small frame_cnt", frame_cnt2, (f + 1) % 256);
        end
        check("small frame_done pulses", done2_hi, 256);
        check("small frame_cnt wrapped", frame_cnt2, 0);
        check("small idle busy", busy2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
